hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard/stall controller for the 5-stage MIPS pipeline. It is the sequential successor to the combinational D-stage stall check.

- Keeps a registered scoreboard of destination register and remaining-latency (Tnew) for the E, M and W stages.
- Compares each D-stage source's Tuse against the youngest matching in-flight writer.
- Resolves conditional writes (movz class) in E.
- Tracks a multi-cycle mult/div unit with a busy counter.
- Outputs the stall/bubble control and the per-source forwarding stage.

## Interface
Parameters:
- REG_AW, 5, register address width; register 0 is never a hazard
- TNEW_W, 2, width of Tnew fields
- MD_MULT_CYC, 5, busy cycles after a mult-class op leaves E
- MD_DIV_CYC, 10, busy cycles after a div-class op leaves E
- MD_CW, 4, busy counter width; must hold MD_DIV_CYC

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- d_rs_addr  in  REG_AW  D-stage rs
- d_rs_tuse  in  2  cycles until rs is consumed (0, 1, 2); 3 = rs unused
- d_rt_addr  in  REG_AW  D-stage rt
- d_rt_tuse  in  2  as d_rs_tuse, for rt
- d_dst_addr  in  REG_AW  D-stage destination; 0 = no write
- d_tnew  in  TNEW_W  cycles from E entry until the result exists (jal 0, ALU 1, load/mfc0 2)
- d_md_op  in  2  00 none, 01 mult-class start, 10 div-class start, 11 HI/LO access
- e_write_en  in  1  conditional-write resolution for the instruction now in E; 0 cancels its write
- flush  in  1  insert a bubble into E this cycle (branch/exception squash)
- stall  out  1  freeze PC and IF/ID; bubble ID/EX
- md_busy  out  1  mult/div unit occupied
- fwd_rs_stage  out  2  youngest in-flight writer of rs: 0 none, 1 E, 2 M, 3 W
- fwd_rt_stage  out  2  same, for rt

## Operation
- Entry fields: dst, tnew, md_op. There are three registered entries: E, M and W. A bubble entry is dst=0, tnew=0, md_op=00.
- Effective E dst is 0 when e_write_en=0. This applies both to hazard comparison and when the E entry advances to M.
- Match per source: source is used (tuse≠3), address≠0, and it equals a stage dst. Only the youngest match is considered, with priority E > M > W.
- Register stall term: the youngest match's tnew > source tuse.
- fwd_*_stage reports the youngest match regardless of readiness, or 0 if there is no match.
- md_busy = (counter≠0) OR (E md_op is 01 or 10).
- md stall term: d_md_op≠00 AND md_busy.
- stall = OR of the rs term, the rt term and the md term.
- Advance every cycle:
  - W ← M with tnew decremented, saturating at 0.
  - M ← E (effective dst) with tnew decremented, saturating at 0.
  - E ← bubble if stall OR flush; otherwise E ← D inputs.
- Counter:
  - If E md_op=01, load MD_MULT_CYC.
  - Else if E md_op=10, load MD_DIV_CYC.
  - Else, if nonzero, decrement.
  - flush does not abort a launched op.
- Simultaneous stall and flush: a single bubble enters E; no other effect.

## Timing
- stall, md_busy and fwd_*_stage are combinational from D inputs, e_write_en and the registered state. They are valid in the same cycle.
- Scoreboard and counter update on the rising clk edge.
- Reset, one edge:
  - All entries become bubbles and the counter becomes 0.
  - Outputs are then stall=0, md_busy=0 and fwd_*_stage=0 for any D input with tuse=3 and md_op=00.
- Reset mid-operation discards all pending writes and the md busy state.
- Load-use (tnew 2, tuse 1): 1 stall cycle. Load-branch (tuse 0): 2 cycles. ALU-branch: 1 cycle.
- HI/LO access immediately after mult: MD_MULT_CYC+1 stall cycles.

## Configuration
- HAZARD_MD_EN defined: the mult/div counter and md stall term are built as above.
- HAZARD_MD_EN undefined:
  - The counter is absent and md_busy is tied to 0.
  - d_md_op is ignored.
  - The md field is not stored.
  - stall depends only on register terms.

## Test plan
- lw $2 (tnew 2) then addu $3,$2,$2 (tuse 1) -> stall=1 for exactly 1 cycle; next cycle fwd_rs_stage=2, fwd_rt_stage=2, stall=0.
- lw $2 then beq $2,$4 (rs tuse 0) -> stall=1 for 2 cycles; then fwd_rs_stage=3, fwd_rt_stage=0.
- addu $0,$1,$1 then beq $0,$0 -> stall=0, fwd_*_stage=0 throughout.
- movz $5 in E:
  - with e_write_en=0 and beq $5 in D -> stall=0, fwd_rs_stage=0.
  - with e_write_en=1 -> stall=1 for 1 cycle.
- mult (MD_MULT_CYC=5) then mflo -> stall=1 for 6 cycles, md_busy falls after the 6th; with HAZARD_MD_EN undefined -> stall=0.
- div launched, reset asserted on the 3rd busy cycle -> following cycle md_busy=0 and stall=0; a lw $2 entry in M is gone (add $3,$2 in D gives fwd_rs_stage=0).

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle between the pipeline (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2
);
    logic [REG_AW-1:0] d_rs_addr;
    logic [1:0]        d_rs_tuse;
    logic [REG_AW-1:0] d_rt_addr;
    logic [1:0]        d_rt_tuse;
    logic [REG_AW-1:0] d_dst_addr;
    logic [TNEW_W-1:0] d_tnew;
    logic [1:0]        d_md_op;
    logic              e_write_en;
    logic              flush;
    logic              stall;
    logic              md_busy;
    logic [1:0]        fwd_rs_stage;
    logic [1:0]        fwd_rt_stage;

    modport master (
        output d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_dst_addr, d_tnew, d_md_op,
        output e_write_en, flush,
        input  stall, md_busy, fwd_rs_stage, fwd_rt_stage
    );

    modport slave (
        input  d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_dst_addr, d_tnew, d_md_op,
        input  e_write_en, flush,
        output stall, md_busy, fwd_rs_stage, fwd_rt_stage
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Registered E/M/W writer scoreboard producing D-stage stall and forwarding-stage selects.
// Define HAZARD_MD_EN to build the mult/div busy counter and its stall term.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int TNEW_W      = 2,
    parameter int MD_MULT_CYC = 5,
    parameter int MD_DIV_CYC  = 10,
    parameter int MD_CW       = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int CW = (TNEW_W > 2) ? TNEW_W : 2;

    logic [REG_AW-1:0] e_dst_q, m_dst_q, w_dst_q;
    logic [REG_AW-1:0] e_dst_d, m_dst_d, w_dst_d;
    logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, w_tnew_q;
    logic [TNEW_W-1:0] e_tnew_d, m_tnew_d, w_tnew_d;
    logic [REG_AW-1:0] e_dst_eff;
    logic              md_busy, stall_md, stall_all, bubble;

    logic [1:0][REG_AW-1:0] src_addr;
    logic [1:0][1:0]        src_tuse;

    // A cancelled conditional write is invisible both now and once it moves to M.
    assign e_dst_eff = hz.e_write_en ? e_dst_q : '0;
    assign src_addr  = {hz.d_rt_addr, hz.d_rs_addr};
    assign src_tuse  = {hz.d_rt_tuse, hz.d_rs_tuse};

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic              used;
        logic [1:0]        fwd;
        logic              stl;
        logic [TNEW_W-1:0] tnew_m;

        always_comb begin
            used   = (src_tuse[s] != 2'd3) && (src_addr[s] != '0);
            fwd    = 2'd0;
            tnew_m = '0;
            if (used && src_addr[s] == e_dst_eff) begin
                fwd    = 2'd1;
                tnew_m = e_tnew_q;
            end else if (used && src_addr[s] == m_dst_q) begin
                fwd    = 2'd2;
                tnew_m = m_tnew_q;
            end else if (used && src_addr[s] == w_dst_q) begin
                fwd    = 2'd3;
                tnew_m = w_tnew_q;
            end
            stl = (fwd != 2'd0) && (CW'(tnew_m) > CW'(src_tuse[s]));
        end
    end

    assign stall_all       = g_src[0].stl | g_src[1].stl | stall_md;
    assign bubble          = stall_all | hz.flush;
    assign hz.stall        = stall_all;
    assign hz.md_busy      = md_busy;
    assign hz.fwd_rs_stage = g_src[0].fwd;
    assign hz.fwd_rt_stage = g_src[1].fwd;

    always_comb begin
        w_dst_d  = m_dst_q;
        w_tnew_d = (m_tnew_q == '0) ? '0 : m_tnew_q - TNEW_W'(1);
        m_dst_d  = e_dst_eff;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
        e_dst_d  = hz.d_dst_addr;
        e_tnew_d = hz.d_tnew;
        if (bubble) begin
            e_dst_d  = '0;
            e_tnew_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst_q  <= '0;
            e_tnew_q <= '0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            w_dst_q  <= '0;
            w_tnew_q <= '0;
        end else begin
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= w_dst_d;
            w_tnew_q <= w_tnew_d;
        end
    end

`ifdef HAZARD_MD_EN
    logic [1:0]       e_md_q, e_md_d;
    logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
    logic             e_md_launch;

    assign e_md_launch = (e_md_q == 2'b01) || (e_md_q == 2'b10);
    assign md_busy     = (md_cnt_q != '0) || e_md_launch;
    assign stall_md    = (hz.d_md_op != 2'b00) && md_busy;

    // The counter keys off E only, so a squash behind a launched op leaves it running.
    always_comb begin
        e_md_d   = bubble ? 2'b00 : hz.d_md_op;
        md_cnt_d = md_cnt_q;
        if (e_md_q == 2'b01)      md_cnt_d = MD_CW'(MD_MULT_CYC);
        else if (e_md_q == 2'b10) md_cnt_d = MD_CW'(MD_DIV_CYC);
        else if (md_cnt_q != '0)  md_cnt_d = md_cnt_q - MD_CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_md_q   <= 2'b00;
            md_cnt_q <= '0;
        end else begin
            e_md_q   <= e_md_d;
            md_cnt_q <= md_cnt_d;
        end
    end
`else
    logic unused_md;
    assign unused_md = ^{hz.d_md_op, MD_CW'(MD_MULT_CYC), MD_CW'(MD_DIV_CYC)};
    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instruction-history model checked every cycle plus directed scenarios.
module tb_hazard_scoreboard;
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .TNEW_W(2)) hz ();

    hazard_scoreboard #(
        .REG_AW(5), .TNEW_W(2), .MD_MULT_CYC(MULT_N), .MD_DIV_CYC(DIV_N), .MD_CW(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // History of instructions by the cycle in which they sat in E.
    int       now = 0;
    bit       v   [0:1023];
    logic [4:0] dst [0:1023];
    int       tn  [0:1023];
    logic [1:0] md [0:1023];
    bit       wen [0:1023];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, now);
        end
    endtask

    function automatic void src_eval(input logic [4:0] a, input logic [1:0] tu,
                                     output logic [1:0] stg, output logic stl);
        stg = 2'd0;
        stl = 1'b0;
        if (tu == 2'd3 || a == 5'd0) return;
        for (int age = 0; age < 3; age++) begin
            int c;
            logic [4:0] ed;
            int t;
            c = now - age;
            if (c < 0) continue;
            if (!v[c]) continue;
            ed = ((age == 0) ? hz.e_write_en : wen[c]) ? dst[c] : 5'd0;
            if (ed == a) begin
                t = tn[c] - age;
                if (t < 0) t = 0;
                stg = 2'(age + 1);
                stl = (t > int'(tu));
                return;
            end
        end
    endfunction

    function automatic logic m_busy();
        if (!MD_EN) return 1'b0;
        for (int age = 0; age <= DIV_N + 2; age++) begin
            int c;
            c = now - age;
            if (c >= 0 && v[c] && (md[c] == 2'b01 || md[c] == 2'b10))
                return age <= ((md[c] == 2'b01) ? MULT_N : DIV_N);
        end
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        logic [1:0] g1, g2;
        logic s1, s2;
        src_eval(hz.d_rs_addr, hz.d_rs_tuse, g1, s1);
        src_eval(hz.d_rt_addr, hz.d_rt_tuse, g2, s2);
        return s1 | s2 | ((hz.d_md_op != 2'b00) && m_busy());
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] g1, g2;
            logic s1, s2;
            src_eval(hz.d_rs_addr, hz.d_rs_tuse, g1, s1);
            src_eval(hz.d_rt_addr, hz.d_rt_tuse, g2, s2);
            cmp("model_stall", hz.stall, m_stall());
            cmp("model_md_busy", hz.md_busy, m_busy());
            cmp("model_fwd_rs", hz.fwd_rs_stage, g1);
            cmp("model_fwd_rt", hz.fwd_rt_stage, g2);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) v[i] <= 1'b0;
        end else begin
            wen[now] <= hz.e_write_en;
            if (!m_stall() && !hz.flush) begin
                v[now+1]   <= 1'b1;
                dst[now+1] <= hz.d_dst_addr;
                tn[now+1]  <= int'(hz.d_tnew);
                md[now+1]  <= MD_EN ? hz.d_md_op : 2'b00;
            end
        end
        now <= now + 1;
    end

    task automatic drive(input logic [4:0] d, input int t, input logic [4:0] rs, input int rsu,
                         input logic [4:0] rt, input int rtu, input logic [1:0] mdop);
        hz.d_dst_addr = d;
        hz.d_tnew     = 2'(t);
        hz.d_rs_addr  = rs;
        hz.d_rs_tuse  = 2'(rsu);
        hz.d_rt_addr  = rt;
        hz.d_rt_tuse  = 2'(rtu);
        hz.d_md_op    = mdop;
    endtask

    task automatic nop_in();
        drive(5'd0, 0, 5'd0, 3, 5'd0, 3, 2'b00);
    endtask

    task automatic idle(input int n);
        nop_in();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds one instruction in D until it issues; checks stall length and forwarding at issue.
    task automatic send(input string name, input logic [4:0] d, input int t,
                        input logic [4:0] rs, input int rsu, input logic [4:0] rt, input int rtu,
                        input logic [1:0] mdop, input int exp_n, input int exp_frs, input int exp_frt);
        int n;
        n = 0;
        drive(d, t, rs, rsu, rt, rtu, mdop);
        forever begin
            @(negedge clk);
            if (hz.stall !== 1'b1) break;
            n++;
            if (n > 40) break;
            @(posedge clk);
            #1;
        end
        cmp({name, "_stall_cycles"}, n, exp_n);
        if (exp_frs >= 0) cmp({name, "_fwd_rs"}, hz.fwd_rs_stage, exp_frs);
        if (exp_frt >= 0) cmp({name, "_fwd_rt"}, hz.fwd_rt_stage, exp_frt);
        @(posedge clk);
        #1;
        nop_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop_in();
        hz.e_write_en = 1'b1;
        hz.flush      = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        cmp("reset_stall", hz.stall, 0);
        cmp("reset_md_busy", hz.md_busy, 0);
        cmp("reset_fwd_rs", hz.fwd_rs_stage, 0);
        cmp("reset_fwd_rt", hz.fwd_rt_stage, 0);
        @(posedge clk);
        #1;

        // load-use: one stall, then forward from M
        send("lw2", 5'd2, 2, 5'd29, 1, 5'd0, 3, 2'b00, 0, -1, -1);
        send("addu_load_use", 5'd3, 1, 5'd2, 1, 5'd2, 1, 2'b00, 1, 2, 2);
        idle(3);

        // load-branch: two stalls, then forward from W
        send("lw2b", 5'd2, 2, 5'd29, 1, 5'd0, 3, 2'b00, 0, -1, -1);
        send("beq_load", 5'd0, 0, 5'd2, 0, 5'd4, 0, 2'b00, 2, 3, 0);
        idle(3);

        // register 0 never hazards
        send("addu_r0", 5'd0, 1, 5'd1, 1, 5'd1, 1, 2'b00, 0, 0, 0);
        send("beq_r0", 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0);
        idle(3);

        // cancelled conditional write
        send("movz_cancel", 5'd5, 1, 5'd6, 1, 5'd7, 1, 2'b00, 0, -1, -1);
        hz.e_write_en = 1'b0;
        send("beq5_cancel", 5'd0, 0, 5'd5, 0, 5'd0, 3, 2'b00, 0, 0, 0);
        hz.e_write_en = 1'b1;
        idle(3);

        // taken conditional write: ALU-branch single stall
        send("movz_take", 5'd5, 1, 5'd6, 1, 5'd7, 1, 2'b00, 0, -1, -1);
        send("beq5_take", 5'd0, 0, 5'd5, 0, 5'd0, 3, 2'b00, 1, 2, 0);
        idle(3);

        // mult then mflo
        send("mult", 5'd0, 0, 5'd20, 1, 5'd21, 1, 2'b01, 0, -1, -1);
        send("mflo", 5'd8, 1, 5'd0, 3, 5'd0, 3, 2'b11, MD_EN ? MULT_N + 1 : 0, 0, 0);
        @(negedge clk);
        cmp("md_busy_after_mflo", hz.md_busy, 0);
        @(posedge clk);
        #1;

        // squashed load leaves no writer behind
        hz.flush = 1'b1;
        send("lw9_flushed", 5'd9, 2, 5'd29, 1, 5'd0, 3, 2'b00, 0, -1, -1);
        hz.flush = 1'b0;
        send("use9", 5'd10, 1, 5'd9, 1, 5'd0, 3, 2'b00, 0, 0, 0);
        idle(3);

        // div, then lw, reset on the third busy cycle
        send("div", 5'd0, 0, 5'd20, 1, 5'd21, 1, 2'b10, 0, -1, -1);
        send("lw2c", 5'd2, 2, 5'd29, 1, 5'd0, 3, 2'b00, 0, -1, -1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(5'd3, 1, 5'd2, 1, 5'd0, 3, 2'b00);
        @(negedge clk);
        cmp("div_busy_3rd", hz.md_busy, MD_EN);
        cmp("lw_in_M_fwd", hz.fwd_rs_stage, 2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cmp("post_reset_md_busy", hz.md_busy, 0);
        cmp("post_reset_stall", hz.stall, 0);
        cmp("post_reset_fwd_rs", hz.fwd_rs_stage, 0);
        @(posedge clk);
        #1;
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
